// File: rtl/pipe_pkg.sv
// Shared types and default constants for the pipeline skid stage.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_e;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_CNT_W  = 16;

    function automatic logic [1:0] occ_of(input state_e s);
        case (s)
            BUSY:    occ_of = 2'd1;
            FULL:    occ_of = 2'd2;
            default: occ_of = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) count_d = count_q + 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) count_q <= '0;
        else     count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry registered pipeline stage (main + skid) with sticky halt,
// synchronous flush and a saturating downstream-stall counter.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int HALT_BIT = DATA_W - 1,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              halted,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              halted_q, halted_d;
    logic              up, dn;

    // Handshake outputs decode registered state only, so out_ready never
    // reaches in_ready combinationally.
    assign in_ready  = (state_q != FULL) && !halted_q;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign halted    = halted_q;
    assign occupancy = occ_of(state_q);

    assign up = in_valid && in_ready;
    assign dn = out_valid && out_ready;

    always_comb begin
        state_d  = state_q;
        main_d   = main_q;
        skid_d   = skid_q;
        halted_d = halted_q;
        if (flush) begin
            state_d  = EMPTY;
            main_d   = '0;
            skid_d   = '0;
            halted_d = 1'b0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (up) begin
                        state_d = BUSY;
                        main_d  = in_data;
                    end
                end
                BUSY: begin
                    if (up && dn) begin
                        main_d = in_data;
                    end else if (up) begin
                        skid_d  = in_data;
                        state_d = FULL;
                    end else if (dn) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (dn) begin
                        main_d  = skid_q;
                        state_d = BUSY;
                    end
                end
                default: state_d = EMPTY;
            endcase
            if (up && in_data[HALT_BIT]) halted_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= EMPTY;
            main_q   <= '0;
            skid_q   <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            main_q   <= main_d;
            skid_q   <= skid_d;
            halted_q <= halted_d;
        end
    end

    // Flush deliberately does not clear the stall statistic.
    sat_counter #(.CNT_W(CNT_W)) u_stall (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (out_valid && !out_ready),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed + random checks of pipe_skid_stage against a queue-based model.
module tb_pipe_skid_stage;

    localparam int DW   = 32;
    localparam int HB   = DW - 1;
    localparam int CW   = 2;
    localparam int SMAX = (1 << CW) - 1;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          out_ready = 1'b0;
    logic          in_ready, out_valid, halted;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
    logic [CW-1:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mq[$];
    bit            mhalt = 1'b0;
    int            mstall = 0;

    always #5 CLK = ~CLK;

    pipe_skid_stage #(.DATA_W(DW), .HALT_BIT(HB), .CNT_W(CW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .halted    (halted),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("occupancy", {30'd0, occupancy}, mq.size());
        chk("out_valid", {31'd0, out_valid}, {31'd0, mq.size() != 0});
        chk("in_ready",  {31'd0, in_ready},  {31'd0, (mq.size() < 2) && !mhalt});
        chk("halted",    {31'd0, halted},    {31'd0, mhalt});
        chk("stall_cnt", {30'd0, stall_cnt}, mstall);
        if (mq.size() > 0) chk("out_data", out_data, mq[0]);
    endtask

    // Drive one cycle, advance the model by the same edge, then compare.
    task automatic step(input bit r, input bit f, input bit v, input logic [DW-1:0] d, input bit ordy);
        bit up, dn;
        RST = r; flush = f; in_valid = v; in_data = d; out_ready = ordy;
        if (r) begin
            mq.delete(); mhalt = 1'b0; mstall = 0;
        end else begin
            if (mq.size() > 0 && !ordy && mstall < SMAX) mstall++;
            if (f) begin
                mq.delete(); mhalt = 1'b0;
            end else begin
                up = v && (mq.size() < 2) && !mhalt;
                dn = (mq.size() > 0) && ordy;
                if (dn) void'(mq.pop_front());
                if (up) begin
                    mq.push_back(d);
                    if (d[HB]) mhalt = 1'b1;
                end
            end
        end
        @(posedge CLK); #1;
        check_model();
    endtask

    initial begin
        int exp_stall [6] = '{1, 2, 3, 3, 3, 3};
        logic [DW-1:0] rd;

        // Reset
        step(1, 0, 0, '0, 0);
        step(1, 0, 0, '0, 0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data",  out_data, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready}, 32'd1);
        chk("rst_occ",       {30'd0, occupancy}, 32'd0);
        RST = 1'b0;

        // Single-cycle latency from EMPTY
        step(0, 0, 1, 32'h0000_00A5, 1);
        chk("lat_valid", {31'd0, out_valid}, 32'd1);
        chk("lat_data",  out_data, 32'h0000_00A5);
        chk("lat_occ",   {30'd0, occupancy}, 32'd1);
        step(0, 0, 0, '0, 1);

        // Fill to FULL, then drain in order
        step(0, 0, 1, 32'h11, 0);
        step(0, 0, 1, 32'h22, 0);
        chk("full_occ",   {30'd0, occupancy}, 32'd2);
        chk("full_ready", {31'd0, in_ready}, 32'd0);
        chk("drain0",     out_data, 32'h11);
        step(0, 0, 0, '0, 1);
        chk("drain1", out_data, 32'h22);
        step(0, 0, 0, '0, 1);
        chk("drained_occ", {30'd0, occupancy}, 32'd0);

        // Flush while FULL drops the concurrent input
        step(0, 0, 1, 32'h33, 0);
        step(0, 0, 1, 32'h44, 0);
        step(0, 1, 1, 32'h55, 0);
        chk("flush_occ",  {30'd0, occupancy}, 32'd0);
        chk("flush_data", out_data, 32'd0);
        step(0, 0, 0, '0, 1);
        chk("flush_no55", {31'd0, out_valid}, 32'd0);

        // Stall counter saturation
        step(1, 0, 0, '0, 0);
        step(0, 0, 1, 32'h66, 0);
        chk("stall_start", {30'd0, stall_cnt}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, '0, 0);
            chk($sformatf("stall_%0d", i), {30'd0, stall_cnt}, exp_stall[i]);
        end

        // Halt is sticky until flush
        step(0, 1, 0, '0, 1);
        step(0, 0, 1, 32'h8000_0001, 1);
        chk("halt_set",   {31'd0, halted}, 32'd1);
        chk("halt_ready", {31'd0, in_ready}, 32'd0);
        step(0, 0, 1, 32'h77, 1);
        chk("halt_drop",  {30'd0, occupancy}, 32'd0);
        chk("halt_stick", {31'd0, halted}, 32'd1);
        step(0, 1, 0, '0, 1);
        chk("halt_clr",   {31'd0, halted}, 32'd0);
        chk("halt_ready2", {31'd0, in_ready}, 32'd1);

        // Reset wins over flush while FULL
        step(0, 0, 1, 32'h33, 0);
        step(0, 0, 1, 32'h44, 0);
        step(1, 1, 1, 32'h99, 0);
        chk("rf_occ",   {30'd0, occupancy}, 32'd0);
        chk("rf_data",  out_data, 32'd0);
        chk("rf_valid", {31'd0, out_valid}, 32'd0);
        chk("rf_ready", {31'd0, in_ready}, 32'd1);
        chk("rf_stall", {30'd0, stall_cnt}, 32'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rd = $urandom;
            if ($urandom_range(15) != 0) rd[HB] = 1'b0;
            step(($urandom_range(60) == 0), ($urandom_range(20) == 0),
                 ($urandom_range(3) != 0), rd, ($urandom_range(2) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
